// File: rtl/uart_pkg.sv
// Shared FSM encoding, parity/ASCII constants and hex helper for the block UART transmitter.
package uart_pkg;

    // The inter-character NEXT step costs no line time, so it is a combinational
    // hand-off rather than a registered state.
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-frame UART serialiser: start, 8 data bits LSB first, optional parity, stop bits.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       byte_valid_i,
    input  logic [7:0] byte_i,
    output logic       byte_ready_o,
    output logic       frame_done_o,
    output logic       tx_o
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

    tx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic            stop_idx_q, stop_idx_d;
    logic [7:0]      data_q, data_d;
    logic            tx_q, tx_d;
    logic            bit_last;
    logic            load;

    assign bit_last     = (cnt_q == CntW'(CLKS_PER_BIT - 1));
    assign frame_done_o = (state_q == StStop) && bit_last && (stop_idx_q == 1'(STOP_BITS - 1));
    // Ready during the final stop cycle lets the next start bit follow with no gap.
    assign byte_ready_o = (state_q == StIdle) || frame_done_o;
    assign load         = byte_valid_i && byte_ready_o;
    assign tx_o         = tx_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = (state_q == StIdle || bit_last) ? '0 : cnt_q + CntW'(1);
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        data_d     = data_q;
        tx_d       = tx_q;

        unique case (state_q)
            StIdle: tx_d = 1'b1;
            StStart: begin
                if (bit_last) begin
                    state_d   = StData;
                    bit_idx_d = 3'd0;
                    tx_d      = data_q[0];
                end
            end
            StData: begin
                if (bit_last) begin
                    if (bit_idx_q == 3'd7) begin
                        if (PARITY != PAR_NONE) begin
                            state_d = StParity;
                            tx_d    = (^data_q) ^ (PARITY == PAR_ODD);
                        end else begin
                            state_d    = StStop;
                            stop_idx_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = data_q[bit_idx_q + 3'd1];
                    end
                end
            end
            StParity: begin
                if (bit_last) begin
                    state_d    = StStop;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            StStop: begin
                if (bit_last) begin
                    if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                        state_d = StIdle;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                    tx_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            state_d = StStart;
            cnt_d   = '0;
            data_d  = byte_i;
            tx_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            data_q     <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            data_q     <= data_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: rtl/block_uart_tx.sv
// Block-level UART transmitter: latches a wide block and sequences raw or ASCII-hex characters.
module block_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned BLOCK_BYTES  = 16,
    parameter int unsigned HEX_MODE     = 0,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [8*BLOCK_BYTES-1:0] i_block,
    output logic                     o_uart_tx,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int unsigned W    = 8 * BLOCK_BYTES;
    localparam int unsigned N    = (HEX_MODE != 0) ? 2 * BLOCK_BYTES + 2 : BLOCK_BYTES;
    localparam int unsigned Step = (HEX_MODE != 0) ? 4 : 8;
    localparam int unsigned CntW = $clog2(N + 1);

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [W-1:0]    shift_q, shift_d;
    logic [CntW-1:0] char_cnt_q, char_cnt_d;
    logic            accept;
    logic            frame_done;
    logic            byte_ready;
    logic            byte_valid;
    logic [7:0]      char_sel;

    // `left` counts characters still owed including this one; CR/LF close a hex block.
    function automatic logic [7:0] pick_char(input logic [7:0] top, input logic [CntW-1:0] left);
        if (HEX_MODE == 0) return top;
        if (left == CntW'(2)) return CHAR_CR;
        if (left == CntW'(1)) return CHAR_LF;
        return hex_char(top[7:4]);
    endfunction

    assign accept  = i_valid && !busy_q;
    assign o_ready = !busy_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

    always_comb begin
        shift_d    = shift_q;
        char_cnt_d = char_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        byte_valid = 1'b0;

        if (accept) begin
            shift_d    = i_block;
            char_cnt_d = CntW'(N);
            busy_d     = 1'b1;
            byte_valid = 1'b1;
        end else if (busy_q && frame_done) begin
            shift_d    = shift_q << Step;
            char_cnt_d = char_cnt_q - CntW'(1);
            if (char_cnt_q == CntW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                byte_valid = 1'b1;
            end
        end

        char_sel = pick_char(shift_d[W-1 -: 8], char_cnt_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            shift_q    <= '0;
            char_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            done_q     <= done_d;
            shift_q    <= shift_d;
            char_cnt_q <= char_cnt_d;
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .PARITY       (PARITY),
        .STOP_BITS    (STOP_BITS)
    ) u_byte_tx (
        .clk_i        (clk),
        .rst_i        (rst),
        .byte_valid_i (byte_valid),
        .byte_i       (char_sel),
        .byte_ready_o (byte_ready),
        .frame_done_o (frame_done),
        .tx_o         (o_uart_tx)
    );

    // byte_ready is implied by the block-level sequencing; kept for the handshake contract.
    logic unused_ready;
    assign unused_ready = byte_ready;

endmodule

// File: tb/tb_block_uart_tx.sv
// Bench for block_uart_tx: five configurations checked cycle-by-cycle against a frame-level model.
module tb_block_uart_tx;

    localparam int CPB [5] = '{4, 4, 3, 3, 2};
    localparam int BB  [5] = '{2, 16, 2, 2, 1};
    localparam int HEX [5] = '{0, 1, 0, 0, 0};
    localparam int PAR [5] = '{0, 0, 1, 2, 0};
    localparam int STP [5] = '{1, 1, 2, 2, 1};

    logic         clk = 1'b0;
    logic         rst;
    logic         valid [5];
    logic [127:0] blk   [5];
    logic         ready [5];
    logic         tx    [5];
    logic         busy  [5];
    logic         done  [5];

    int total = 0;
    int bad   = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    block_uart_tx #(.CLKS_PER_BIT(CPB[0]), .BLOCK_BYTES(BB[0]), .HEX_MODE(HEX[0]),
                    .PARITY(PAR[0]), .STOP_BITS(STP[0])) u_raw (
        .clk(clk), .rst(rst), .i_valid(valid[0]), .o_ready(ready[0]), .i_block(blk[0][15:0]),
        .o_uart_tx(tx[0]), .o_busy(busy[0]), .o_done(done[0]));

    block_uart_tx #(.CLKS_PER_BIT(CPB[1]), .BLOCK_BYTES(BB[1]), .HEX_MODE(HEX[1]),
                    .PARITY(PAR[1]), .STOP_BITS(STP[1])) u_hex (
        .clk(clk), .rst(rst), .i_valid(valid[1]), .o_ready(ready[1]), .i_block(blk[1]),
        .o_uart_tx(tx[1]), .o_busy(busy[1]), .o_done(done[1]));

    block_uart_tx #(.CLKS_PER_BIT(CPB[2]), .BLOCK_BYTES(BB[2]), .HEX_MODE(HEX[2]),
                    .PARITY(PAR[2]), .STOP_BITS(STP[2])) u_even (
        .clk(clk), .rst(rst), .i_valid(valid[2]), .o_ready(ready[2]), .i_block(blk[2][15:0]),
        .o_uart_tx(tx[2]), .o_busy(busy[2]), .o_done(done[2]));

    block_uart_tx #(.CLKS_PER_BIT(CPB[3]), .BLOCK_BYTES(BB[3]), .HEX_MODE(HEX[3]),
                    .PARITY(PAR[3]), .STOP_BITS(STP[3])) u_odd (
        .clk(clk), .rst(rst), .i_valid(valid[3]), .o_ready(ready[3]), .i_block(blk[3][15:0]),
        .o_uart_tx(tx[3]), .o_busy(busy[3]), .o_done(done[3]));

    block_uart_tx #(.CLKS_PER_BIT(CPB[4]), .BLOCK_BYTES(BB[4]), .HEX_MODE(HEX[4]),
                    .PARITY(PAR[4]), .STOP_BITS(STP[4])) u_min (
        .clk(clk), .rst(rst), .i_valid(valid[4]), .o_ready(ready[4]), .i_block(blk[4][7:0]),
        .o_uart_tx(tx[4]), .o_busy(busy[4]), .o_done(done[4]));

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic void add_bit(input int k, input logic b);
        for (int r = 0; r < CPB[k]; r++) exp_q.push_back(b);
    endfunction

    // Expected line level for every cycle after acceptance, built from characters and frames.
    function automatic void build_expect(input int k, input logic [127:0] data);
        logic [7:0] chars[$];
        logic [7:0] b;
        string      s;
        exp_q.delete();
        for (int i = 0; i < BB[k]; i++) begin
            b = data[8*(BB[k]-1-i) +: 8];
            if (HEX[k] != 0) begin
                s = $sformatf("%02h", b);
                chars.push_back(s[0]);
                chars.push_back(s[1]);
            end else begin
                chars.push_back(b);
            end
        end
        if (HEX[k] != 0) begin
            chars.push_back(8'h0D);
            chars.push_back(8'h0A);
        end
        foreach (chars[j]) begin
            add_bit(k, 1'b0);
            for (int i = 0; i < 8; i++) add_bit(k, chars[j][i]);
            if (PAR[k] == 1) add_bit(k, ^chars[j]);
            if (PAR[k] == 2) add_bit(k, ~^chars[j]);
            for (int i = 0; i < STP[k]; i++) add_bit(k, 1'b1);
        end
    endfunction

    // Sends one block; returns at the falling edge of the expected o_done cycle.
    task automatic xfer(input int k, input logic [127:0] data, input bit glitch,
                        input bit nowait, input string name);
        int   len;
        int   errs = 0;
        int   first = -1;
        logic got_b = 1'b0;
        logic exp_b = 1'b0;
        int   early = 0;
        int   busy_bad = 0;
        build_expect(k, data);
        len = exp_q.size();
        if (!nowait) repeat (2) @(negedge clk);
        total++;
        if (ready[k] !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_before: got %b want 1", name, ready[k]);
        end
        valid[k] = 1'b1;
        blk[k]   = data;
        @(posedge clk);
        #1;
        valid[k] = 1'b0;
        blk[k]   = rand128();
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            if (tx[k] !== exp_q[c-1]) begin
                errs++;
                if (first < 0) begin
                    first = c;
                    got_b = tx[k];
                    exp_b = exp_q[c-1];
                end
            end
            if (done[k] !== 1'b0) early++;
            if (busy[k] !== 1'b1 || ready[k] !== 1'b0) busy_bad++;
            if (glitch) begin
                valid[k] = (c == len / 2);
                if (c == len / 2) blk[k] = 128'h1234;
            end
        end
        valid[k] = 1'b0;
        @(negedge clk);
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s line: %0d bad cycles, first at %0d got %b want %b",
                     name, errs, first, got_b, exp_b);
        end
        total++;
        if (busy_bad != 0) begin
            bad++;
            $display("FAIL %s busy_window: %0d cycles not busy/not-ready, want 0", name, busy_bad);
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL %s early_done: %0d pulses during line, want 0", name, early);
        end
        total++;
        if (done[k] !== 1'b1 || busy[k] !== 1'b0 || ready[k] !== 1'b1 || tx[k] !== 1'b1) begin
            bad++;
            $display("FAIL %s done_cycle %0d: done=%b busy=%b ready=%b tx=%b want 1 0 1 1",
                     name, len + 1, done[k], busy[k], ready[k], tx[k]);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 5; k++) begin
            total++;
            if (tx[k] !== 1'b1 || ready[k] !== 1'b1 || busy[k] !== 1'b0 || done[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_state[%0d]: tx=%b ready=%b busy=%b done=%b want 1 1 0 0",
                         k, tx[k], ready[k], busy[k], done[k]);
            end
        end
    endtask

    task automatic test_raw();
        xfer(0, 128'hA55A, 1'b0, 1'b0, "raw_a55a");
        for (int i = 0; i < 3; i++) xfer(0, rand128(), 1'b0, 1'b0, "raw_rand");
    endtask

    task automatic test_hex();
        xfer(1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, 1'b0, "hex_fips");
        xfer(1, rand128(), 1'b0, 1'b0, "hex_rand");
    endtask

    task automatic test_parity();
        xfer(2, 128'h0707, 1'b0, 1'b0, "even_07");
        xfer(3, 128'h0707, 1'b0, 1'b0, "odd_07");
        for (int i = 0; i < 2; i++) begin
            xfer(2, rand128(), 1'b0, 1'b0, "even_rand");
            xfer(3, rand128(), 1'b0, 1'b0, "odd_rand");
        end
    endtask

    task automatic test_min_timing();
        xfer(4, 128'h00, 1'b0, 1'b0, "min_00");
        xfer(4, rand128(), 1'b0, 1'b0, "min_rand");
    endtask

    task automatic test_ignore_busy();
        xfer(0, 128'hA55A, 1'b1, 1'b0, "ignore_valid");
    endtask

    task automatic test_back_to_back();
        xfer(0, rand128(), 1'b0, 1'b0, "b2b_first");
        xfer(0, rand128(), 1'b0, 1'b1, "b2b_second");
        xfer(4, rand128(), 1'b0, 1'b0, "b2b_min_first");
        xfer(4, rand128(), 1'b0, 1'b1, "b2b_min_second");
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int high_bad = 0;
        @(negedge clk);
        valid[0] = 1'b1;
        blk[0]   = 128'hA55A;
        @(negedge clk);
        valid[0] = 1'b0;
        // Now in cycle 1; data bit 3 of 0xA5 (a 0) spans cycles 17..20.
        repeat (17) @(negedge clk);
        total++;
        if (tx[0] !== 1'b0) begin
            bad++;
            $display("FAIL mid_bit3_level: got %b want 0", tx[0]);
        end
        rst = 1'b1;
        #1;
        total++;
        if (tx[0] !== 1'b1 || ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_async: tx=%b ready=%b busy=%b want 1 1 0",
                     tx[0], ready[0], busy[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done[0] !== 1'b0) pulses++;
            if (tx[0] !== 1'b1 || ready[0] !== 1'b1) high_bad++;
        end
        total++;
        if (pulses != 0 || high_bad != 0) begin
            bad++;
            $display("FAIL mid_reset_quiet: done pulses=%0d idle errors=%0d want 0 0",
                     pulses, high_bad);
        end
        xfer(0, rand128(), 1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            valid[k] = 1'b0;
            blk[k]   = '0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_raw();
        test_hex();
        test_parity();
        test_min_timing();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
